thread_latency_model: RTL

Parametrised multi-thread execution stand-in for the Arya core, used at the scheduler boundary before real thread pipelines exist. Each thread slot accepts a start with a programmable run length, reports busy, and pulses done on completion. It supports global stall and per-thread abort. Completions are also queued into a round-robin arbitrated completion port, so the scheduler can retire threads one at a time with backpressure.

---
 rtl/thread_latency_model.sv | 133 +++++++++++++
 1 files changed

// File: rtl/thread_latency_model.sv
// Multi-thread execution stand-in: per-slot run-length timers with stall/abort,
// plus a round-robin arbitrated completion port with sticky overrun flags.
module thread_latency_model #(
  parameter int NUM_THREADS = 8,
  parameter int CNT_WIDTH   = 8,
  parameter int ID_WIDTH    = $clog2(NUM_THREADS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             en,
  input  logic [NUM_THREADS-1:0]           start_thread,
  input  logic [NUM_THREADS*CNT_WIDTH-1:0] latency,
  input  logic [NUM_THREADS-1:0]           abort,
  output logic [NUM_THREADS-1:0]           thread_busy,
  output logic [NUM_THREADS-1:0]           thread_done,
  output logic                             done_valid,
  output logic [ID_WIDTH-1:0]              done_id,
  input  logic                             done_ready,
  output logic [NUM_THREADS-1:0]           overrun
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e               state_q [NUM_THREADS];
  state_e               state_d [NUM_THREADS];
  logic [CNT_WIDTH-1:0] cnt_q   [NUM_THREADS];
  logic [CNT_WIDTH-1:0] cnt_d   [NUM_THREADS];

  logic [NUM_THREADS-1:0] done_q, done_d;
  logic [NUM_THREADS-1:0] pending_q, pending_d;
  logic [NUM_THREADS-1:0] overrun_q, overrun_d;
  logic [ID_WIDTH-1:0]    rr_q, rr_d;
  logic [ID_WIDTH-1:0]    sel_id;
  logic                   handshake;

  always_comb begin
    for (int unsigned i = 0; i < NUM_THREADS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      done_d[i]  = 1'b0;
      if (en) begin
        unique case (state_q[i])
          IDLE: begin
            if (start_thread[i] && !abort[i]) begin
              state_d[i] = BUSY;
              cnt_d[i]   = latency[CNT_WIDTH*i +: CNT_WIDTH];
            end
          end
          BUSY: begin
            // Abort beats completion when both land on the same cycle.
            if (abort[i]) begin
              state_d[i] = IDLE;
            end else if (cnt_q[i] != '0) begin
              cnt_d[i] = cnt_q[i] - 1'b1;
            end else begin
              state_d[i] = IDLE;
              done_d[i]  = 1'b1;
            end
          end
          default: state_d[i] = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_THREADS; i++) begin
      thread_busy[i] = (state_q[i] == BUSY);
    end
  end

  // First pending slot at or above rr, wrapping past the top.
  always_comb begin
    logic        found;
    int unsigned idx;
    found  = 1'b0;
    sel_id = '0;
    idx    = 0;
    for (int unsigned k = 0; k < NUM_THREADS; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_THREADS) idx = idx - NUM_THREADS;
      if (!found && pending_q[idx]) begin
        found  = 1'b1;
        sel_id = ID_WIDTH'(idx);
      end
    end
  end

  assign done_valid = |pending_q;
  assign done_id    = sel_id;
  assign handshake  = done_valid && done_ready;

  always_comb begin
    int unsigned nxt;
    nxt       = int'(sel_id) + 1;
    if (nxt >= NUM_THREADS) nxt = 0;
    rr_d      = rr_q;
    pending_d = pending_q;
    if (handshake) begin
      pending_d[sel_id] = 1'b0;
      rr_d              = ID_WIDTH'(nxt);
    end
    // A new completion re-arms its bit even if it is being retired this cycle.
    pending_d = pending_d | done_d;
    overrun_d = overrun_q | (done_d & pending_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_THREADS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      done_q    <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      rr_q      <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_THREADS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      done_q    <= done_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      rr_q      <= rr_d;
    end
  end

  assign thread_done = done_q;
  assign overrun     = overrun_q;

endmodule
